// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and default parameters for the fifo write arbiter
package fifo_arb_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_FIFO_DEPTH_LOG = 3;
    localparam int DEF_BURST_LEN      = 4;
endpackage

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick: combinational round-robin pick of the first request at or after a pointer
module fifo_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_index
);
    // Scan offsets from farthest to nearest so the nearest valid index at or after the pointer wins
    always_comb begin
        int k;
        o_found = 1'b0;
        o_index = '0;
        k       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(i_rr_ptr) + i) % NUM_REQ;
            if (i_req[k]) begin
                o_found = 1'b1;
                o_index = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter feeding many writers into one fifo_sync with credit tracking
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int FIFO_DEPTH_LOG = DEF_FIFO_DEPTH_LOG,
    parameter int BURST_LEN      = DEF_BURST_LEN,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W  = FIFO_DEPTH_LOG + 1,
    localparam int BEAT_W = $clog2(BURST_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    input  logic                          fifo_rd_en,
    output logic [IDX_W-1:0]              grant_id,
    output logic [CNT_W-1:0]              fifo_count,
    output logic                          overflow_err
);
    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [BEAT_W-1:0]  r_beat_cnt;

    logic               w_credit;
    logic               w_owner_valid;
    logic               w_accept;
    logic               w_rd_fire;
    logic               w_last_beat;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [DATA_WIDTH-1:0] w_owner_data;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_index  (w_pick)
    );

    // fifo_count already includes the write in flight, so it alone bounds the credit
    assign w_credit      = (fifo_count < CNT_W'(FIFO_DEPTH)) && !fifo_full;
    assign w_owner_valid = req_valid[grant_id];
    assign w_owner_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign w_accept      = (r_state == BURST) && w_owner_valid && w_credit;
    assign w_rd_fire     = fifo_rd_en && !fifo_empty && (fifo_count != '0);
    assign w_last_beat   = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign w_next_ptr    = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Only the owner sees ready, and only while downstream space remains
    always_comb req_ready = (r_state == BURST && w_credit) ? (NUM_REQ'(1) << grant_id) : '0;

    // Grant FSM: pick an owner in IDLE, release after a full burst or when the owner goes quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            grant_id   <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_found && w_credit) begin
                grant_id   <= w_pick;
                r_beat_cnt <= '0;
                r_state    <= BURST;
            end
        end else if (!w_owner_valid || (w_accept && w_last_beat)) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    // Registered write port: strobe and data one cycle after each accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cs      <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
        end else begin
            fifo_cs    <= 1'b1;
            fifo_wr_en <= w_accept;
            if (w_accept) fifo_data_in <= w_owner_data;
        end
    end

    // Occupancy: accept cannot happen at full and rd_fire is gated at zero, so no clamping needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fifo_count <= '0;
        else     fifo_count <= fifo_count + CNT_W'(w_accept) - CNT_W'(w_rd_fire);
    end

    // Sticky flag for a write strobe landing on a full fifo
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          overflow_err <= 1'b0;
        else if (fifo_wr_en && fifo_full) overflow_err <= 1'b1;
    end
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of writer requesters.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data word width.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the capacity of the downstream fifo_sync.
REQ-004 Parameter FIFO_DEPTH_LOG, default 3, SHALL equal log2(FIFO_DEPTH).
REQ-005 Parameter BURST_LEN, default 4, SHALL set the maximum number of consecutive beats per grant.
REQ-006 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port req_valid, input, NUM_REQ: per-requester write request.
REQ-009 Port req_data, input, NUM_REQ*DATA_WIDTH: per-requester word, requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port req_ready, output, NUM_REQ: per-requester accept; a beat transfers when valid and ready are both high at a rising edge.
REQ-011 Port fifo_cs, output, 1: chip select to fifo_sync.
REQ-012 Port fifo_wr_en, output, 1: registered write strobe to fifo_sync.
REQ-013 Port fifo_data_in, output, DATA_WIDTH: registered write data to fifo_sync.
REQ-014 Port fifo_full, input, 1; port fifo_empty, input, 1: status from fifo_sync.
REQ-015 Port fifo_rd_en, input, 1: consumer read strobe to fifo_sync, monitored only.
REQ-016 Port grant_id, output, clog2(NUM_REQ): index of the current owner.
REQ-017 Port fifo_count, output, FIFO_DEPTH_LOG+1: tracked occupancy, including any in-flight write.
REQ-018 Port overflow_err, output, 1: sticky error flag.

Function
REQ-019 The FSM SHALL have two states: IDLE (no owner) and BURST (one owner).
REQ-020 In IDLE with any req_valid high and credit available, the block SHALL select the first valid index at or after rr_ptr (wrapping at NUM_REQ), load it into grant_id, clear beat_cnt, and enter BURST the next cycle.
REQ-021 Credit SHALL be available when fifo_count < FIFO_DEPTH and fifo_full is 0.
REQ-022 In BURST, req_ready[grant_id] SHALL equal credit available; every other req_ready bit SHALL be 0; in IDLE all req_ready bits SHALL be 0.
REQ-023 On each accepted beat, fifo_wr_en SHALL be 1 and fifo_data_in SHALL equal the accepted word in the following cycle (1-cycle latency); otherwise fifo_wr_en SHALL be 0 and fifo_data_in SHALL hold.
REQ-024 BURST SHALL return to IDLE, with rr_ptr set to (grant_id+1) mod NUM_REQ, after the BURST_LEN-th accepted beat or in any cycle the owner's req_valid is 0.
REQ-025 In BURST with no credit, the block SHALL keep the grant, hold beat_cnt, and not time out.
REQ-026 fifo_count SHALL update as count + accept - rd_fire, where rd_fire = fifo_rd_en & ~fifo_empty; a simultaneous accept and rd_fire SHALL leave it unchanged.
REQ-027 fifo_count SHALL never exceed FIFO_DEPTH or drop below 0; a rd_fire at count 0 SHALL be ignored.
REQ-028 overflow_err SHALL be set when fifo_wr_en and fifo_full are both 1, and SHALL clear only on reset.
REQ-029 fifo_cs SHALL be 1 in every cycle after reset is released.

Reset
REQ-030 While rst is 1, state SHALL be IDLE, and rr_ptr, grant_id, beat_cnt, fifo_count, fifo_cs, fifo_wr_en, fifo_data_in, req_ready and overflow_err SHALL all be 0.
REQ-031 Reset asserted mid-burst SHALL drop any in-flight write; the downstream fifo_sync SHALL be reset by the same event.

Structure
REQ-032 Package fifo_arb_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 Round-robin selection SHALL be a combinational sub-module, fifo_arb_rr_pick (inputs: req vector and rr_ptr; outputs: found and index).

Verification
REQ-034 The bench SHALL cover: single requester 0 sends 1,10,100 -> fifo_wr_en pulses one cycle after each acceptance; reads return 1,10,100; fifo_count goes 0→3→0.
REQ-035 The bench SHALL cover: all 4 requesters continuously valid with BURST_LEN=4 -> grant order 0,1,2,3,0; each burst is 4 beats; one IDLE cycle between bursts.
REQ-036 The bench SHALL cover: requester 2 sends 9 words with no reads -> 8 accepted, req_ready low with fifo_count=8, grant held; one rd_fire -> 9th word accepted; overflow_err stays 0.
REQ-037 The bench SHALL cover: fifo_count=8 with a simultaneous read and a pending write -> count stays 8 after the accept; with count=0 and fifo_rd_en high -> count stays 0.
REQ-038 The bench SHALL cover: rst pulsed while fifo_count=5 mid-burst -> all outputs 0 immediately; after release, first grant goes to requester 0.
REQ-039 The bench SHALL cover: fifo_full forced to 1 with wr_en injected -> overflow_err=1 and sticky until rst.
